// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for the EX-stage HI/LO divide path.
// One quotient bit per clock; signed operands are divided as magnitudes.
module div_iter #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CW = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    S_FREE,
    S_DBZ,
    S_ON,
    S_END
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]     dvd_q, dvd_d;
  logic [DATA_W-1:0]     dvs_q, dvs_d;
  logic [DATA_W-1:0]     rem_q, rem_d;
  logic                  negq_q, negq_d;
  logic                  negr_q, negr_d;
  logic                  ready_q, ready_d;
  logic [2*DATA_W-1:0]   result_q, result_d;

  logic [DATA_W:0]       shifted;
  logic                  ge;
  logic [DATA_W-1:0]     abs1, abs2;
  logic [DATA_W-1:0]     quo_fix, rem_fix;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    ready_d  = ready_q;
    result_d = result_q;

    // dvd_q shifts the dividend out and the quotient in
    shifted = {rem_q, dvd_q[DATA_W-1]};
    ge      = shifted >= {1'b0, dvs_q};

    abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    quo_fix = negq_q ? -dvd_q : dvd_q;
    rem_fix = negr_q ? -rem_q : rem_q;

    unique case (state_q)
      S_FREE: begin
        if (start_i && !annul_i) begin
          rem_d = '0;
          if (opdata2_i == '0) begin
            state_d = S_DBZ;
            dvd_d   = '0;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
          end else begin
            state_d = S_ON;
            cnt_d   = '0;
            dvd_d   = abs1;
            dvs_d   = abs2;
            negq_d  = signed_div_i &
                      (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            negr_d  = signed_div_i & opdata1_i[DATA_W-1];
          end
        end
      end
      S_DBZ: begin
        state_d = annul_i ? S_FREE : S_END;
      end
      S_ON: begin
        if (annul_i) begin
          state_d = S_FREE;
          cnt_d   = '0;
        end else begin
          rem_d = ge ? DATA_W'(shifted - {1'b0, dvs_q})
                     : shifted[DATA_W-1:0];
          dvd_d = {dvd_q[DATA_W-2:0], ge};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DATA_W - 1)) begin
            state_d = S_END;
          end
        end
      end
      S_END: begin
        // first END cycle publishes; afterwards wait for start_i to drop
        if (!ready_q) begin
          ready_d  = 1'b1;
          result_d = {rem_fix, quo_fix};
        end else if (!start_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: begin
        state_d = S_FREE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: latency, signed/unsigned results,
// divide by zero, annul, mid-run reset and END hold behaviour.
module tb_div_iter;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int n_cmp;
  int n_bad;

  div_iter #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raises start and waits for ready; start is left high on return.
  task automatic do_div(input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_r,
                        input int lat, input string name);
    int n;
    signed_div = s;
    op1 = a;
    op2 = b;
    start = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!ready && n < 100);
    n_cmp++;
    if (n !== lat) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d edges, want %0d", name, n, lat);
    end
    n_cmp++;
    if (result !== exp_r) begin
      n_bad++;
      $display("FAIL %s_result: got %h, want %h", name, result, exp_r);
    end
  endtask

  task automatic release_start(input string name);
    start = 1'b0;
    step();
    n_cmp++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      n_bad++;
      $display("FAIL %s_release: ready=%b result=%h, want 0/0",
               name, ready, result);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    annul = 1'b0;
    step();
    step();
    n_cmp++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      n_bad++;
      $display("FAIL reset: ready=%b result=%h, want 0/0", ready, result);
    end
    start = 1'b0;
    rst = 1'b0;
    step();
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: ready=%b, want 0", ready);
    end
  endtask

  task automatic test_unsigned();
    do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, "u100_7");
    release_start("u100_7");
    do_div(1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 34,
           "uffff_10");
    release_start("uffff_10");
  endtask

  task automatic test_signed();
    do_div(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34, "sm7_2");
    release_start("sm7_2");
    do_div(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34, "s7_m2");
    release_start("s7_m2");
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34,
           "smin_m1");
    release_start("smin_m1");
  endtask

  task automatic test_div_by_zero();
    do_div(1'b0, 32'd5, 32'd0, 64'd0, 3, "udbz");
    release_start("udbz");
    do_div(1'b1, 32'd5, 32'd0, 64'd0, 3, "sdbz");
    release_start("sdbz");
  endtask

  task automatic test_annul();
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    repeat (11) step();
    annul = 1'b1;
    start = 1'b0;
    step();
    annul = 1'b0;
    n_cmp++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      n_bad++;
      $display("FAIL annul: ready=%b result=%h, want 0/0", ready, result);
    end
    do_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34, "annul_9_3");
    release_start("annul_9_3");
  endtask

  task automatic test_reset_mid();
    logic seen;
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    repeat (21) step();
    rst = 1'b1;
    start = 1'b0;
    step();
    rst = 1'b0;
    n_cmp++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      n_bad++;
      $display("FAIL rst_mid: ready=%b result=%h, want 0/0", ready, result);
    end
    seen = 1'b0;
    repeat (20) begin
      step();
      if (ready !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_noready: ready seen=%b, want 0", seen);
    end
  endtask

  task automatic test_hold_end();
    do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, "hold");
    for (int i = 0; i < 5; i++) begin
      annul = (i == 2);
      step();
      n_cmp++;
      if (ready !== 1'b1 || result !== 64'h00000002_0000000E) begin
        n_bad++;
        $display("FAIL hold_%0d: ready=%b result=%h, want 1/%h",
                 i, ready, result, 64'h00000002_0000000E);
      end
    end
    annul = 1'b0;
    release_start("hold");
  endtask

  task automatic test_start_drop();
    int n;
    signed_div = 1'b1;
    op1 = 32'hFFFFFF9C;
    op2 = 32'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    signed_div = 1'b0;
    op1 = 32'h12345678;
    op2 = 32'd0;
    n = 1;
    while (!ready && n < 100) begin
      step();
      n++;
    end
    n_cmp++;
    if (n !== 34) begin
      n_bad++;
      $display("FAIL drop_latency: got %0d edges, want 34", n);
    end
    n_cmp++;
    if (result !== 64'hFFFFFFFE_FFFFFFF2) begin
      n_bad++;
      $display("FAIL drop_result: got %h, want %h",
               result, 64'hFFFFFFFE_FFFFFFF2);
    end
    step();
    n_cmp++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      n_bad++;
      $display("FAIL drop_free: ready=%b result=%h, want 0/0",
               ready, result);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_annul();
    test_reset_mid();
    test_hold_end();
    test_start_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
